vga_timing_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 sync generator.
- Produces hsync, vsync, video_on and pixel coordinates for any mode. Porch and sync widths, sync polarities and pixel clock divide are all parameters.
- All outputs are registered and mutually aligned. Adds a pixel-tick divider, a run enable, and line/frame start strobes.
- Sits between the board clock and the pixel renderer / RGB output stage.

---
 rtl/vga_timing_gen.sv | 149 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/coordinate generator with pixel-tick divider, run enable and line/frame strobes.
// Optional frame counter is built when VGA_FRAME_CNT_EN is defined.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned H_SYNC_POL  = 0,
  parameter int unsigned V_SYNC_POL  = 0,
  parameter int unsigned PIX_DIV     = 1,
  parameter int unsigned COUNT_W     = 10,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  output logic               p_tick,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COUNT_W-1:0] pixel_x,
  output logic [COUNT_W-1:0] pixel_y,
  output logic               line_start,
  output logic               frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_count
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [COUNT_W-1:0] H_LAST   = COUNT_W'(H_TOTAL - 1);
  localparam logic [COUNT_W-1:0] V_LAST   = COUNT_W'(V_TOTAL - 1);
  localparam logic [COUNT_W-1:0] H_ACT    = COUNT_W'(H_ACTIVE);
  localparam logic [COUNT_W-1:0] V_ACT    = COUNT_W'(V_ACTIVE);
  localparam logic [COUNT_W-1:0] H_SYNC_S = COUNT_W'(H_ACTIVE + H_FP);
  localparam logic [COUNT_W-1:0] H_SYNC_E = COUNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COUNT_W-1:0] V_SYNC_S = COUNT_W'(V_ACTIVE + V_FP);
  localparam logic [COUNT_W-1:0] V_SYNC_E = COUNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic               H_ASSERT = 1'(H_SYNC_POL);
  localparam logic               V_ASSERT = 1'(V_SYNC_POL);

  logic [DIV_W-1:0]   r_div;
  logic               r_tick;
  logic [COUNT_W-1:0] r_x;
  logic [COUNT_W-1:0] r_y;
  logic               r_hs;
  logic               r_vs;
  logic               r_vo;
  logic               r_ls;
  logic               r_fs;

  logic               w_tick;
  logic               w_h_wrap;
  logic               w_v_wrap;
  logic [COUNT_W-1:0] w_x_nxt;
  logic [COUNT_W-1:0] w_y_nxt;
  logic               w_hs_nxt;
  logic               w_vs_nxt;
  logic               w_vo_nxt;
  logic               w_ls_nxt;
  logic               w_fs_nxt;

  // Pixel-rate divider: holds while en is low
  assign w_tick = en && (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
    end else if (en) begin
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
    end
  end

  // Next coordinates and their region decode, loaded together on the tick edge
  always_comb begin
    w_h_wrap = (r_x == H_LAST);
    w_v_wrap = (r_y == V_LAST);
    w_x_nxt  = w_h_wrap ? '0 : r_x + COUNT_W'(1);
    w_y_nxt  = r_y;
    if (w_h_wrap) begin
      w_y_nxt = w_v_wrap ? '0 : r_y + COUNT_W'(1);
    end
    w_hs_nxt = ((w_x_nxt >= H_SYNC_S) && (w_x_nxt <= H_SYNC_E)) ? H_ASSERT : ~H_ASSERT;
    w_vs_nxt = ((w_y_nxt >= V_SYNC_S) && (w_y_nxt <= V_SYNC_E)) ? V_ASSERT : ~V_ASSERT;
    w_vo_nxt = (w_x_nxt < H_ACT) && (w_y_nxt < V_ACT);
    w_ls_nxt = (w_x_nxt == '0);
    w_fs_nxt = (w_x_nxt == '0) && (w_y_nxt == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick <= 1'b0;
      r_x    <= H_LAST;
      r_y    <= V_LAST;
      r_hs   <= ~H_ASSERT;
      r_vs   <= ~V_ASSERT;
      r_vo   <= 1'b0;
      r_ls   <= 1'b0;
      r_fs   <= 1'b0;
    end else begin
      r_tick <= w_tick;
      r_ls   <= 1'b0;
      r_fs   <= 1'b0;
      if (w_tick) begin
        r_x  <= w_x_nxt;
        r_y  <= w_y_nxt;
        r_hs <= w_hs_nxt;
        r_vs <= w_vs_nxt;
        r_vo <= w_vo_nxt;
        r_ls <= w_ls_nxt;
        r_fs <= w_fs_nxt;
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  // Counts frame_start events; reads 1 during the first frame after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_cnt <= '0;
    end else if (w_tick && w_fs_nxt) begin
      r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
    end
  end

  assign frame_count = r_frame_cnt;
`endif

  assign p_tick      = r_tick;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign video_on    = r_vo;
  assign pixel_x     = r_x;
  assign pixel_y     = r_y;
  assign line_start  = r_ls;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default mode, small 8x6 mode and a PIX_DIV=3 small mode against a
// per-instance reference model feeding expected-output queues. Honours VGA_FRAME_CNT_EN.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        pt;
    logic        hs;
    logic        vs;
    logic        vo;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } exp_t;

`ifdef VGA_FRAME_CNT_EN
  localparam bit FC_ON = 1'b1;
`else
  localparam bit FC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic en_d, en_s, en_p;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  logic        pt_d, hs_d, vs_d, vo_d, ls_d, fs_d;
  logic        pt_s, hs_s, vs_s, vo_s, ls_s, fs_s;
  logic        pt_p, hs_p, vs_p, vo_p, ls_p, fs_p;
  logic [9:0]  x_d, y_d, x_s, y_s, x_p, y_p;
  logic [15:0] fc_d, fc_s, fc_p;

  vga_timing_gen dut_d (
    .clk(clk), .reset_n(reset_n), .en(en_d), .p_tick(pt_d), .hsync(hs_d), .vsync(vs_d),
    .video_on(vo_d), .pixel_x(x_d), .pixel_y(y_d), .line_start(ls_d), .frame_start(fs_d)
`ifdef VGA_FRAME_CNT_EN
    , .frame_count(fc_d)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1), .V_SYNC_POL(1), .PIX_DIV(1)
  ) dut_s (
    .clk(clk), .reset_n(reset_n), .en(en_s), .p_tick(pt_s), .hsync(hs_s), .vsync(vs_s),
    .video_on(vo_s), .pixel_x(x_s), .pixel_y(y_s), .line_start(ls_s), .frame_start(fs_s)
`ifdef VGA_FRAME_CNT_EN
    , .frame_count(fc_s)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(0), .V_SYNC_POL(0), .PIX_DIV(3)
  ) dut_p (
    .clk(clk), .reset_n(reset_n), .en(en_p), .p_tick(pt_p), .hsync(hs_p), .vsync(vs_p),
    .video_on(vo_p), .pixel_x(x_p), .pixel_y(y_p), .line_start(ls_p), .frame_start(fs_p)
`ifdef VGA_FRAME_CNT_EN
    , .frame_count(fc_p)
`endif
  );

`ifndef VGA_FRAME_CNT_EN
  assign fc_d = '0;
  assign fc_s = '0;
  assign fc_p = '0;
`endif

  exp_t act_d, act_s, act_p;
  assign act_d = {pt_d, hs_d, vs_d, vo_d, x_d, y_d, ls_d, fs_d, fc_d};
  assign act_s = {pt_s, hs_s, vs_s, vo_s, x_s, y_s, ls_s, fs_s, fc_s};
  assign act_p = {pt_p, hs_p, vs_p, vo_p, x_p, y_p, ls_p, fs_p, fc_p};

  // Expected outputs from the count of pixel ticks since reset (n=0 is the parked reset position)
  function automatic exp_t f_exp(input int ha, hf, hsw, hb, va, vf, vsw, vb,
                                 input logic hpol, vpol, input longint n,
                                 input logic tick, input int fc);
    exp_t   e;
    int     ht  = ha + hf + hsw + hb;
    int     vt  = va + vf + vsw + vb;
    longint tot = longint'(ht) * longint'(vt);
    longint p   = (n + tot - 1) % tot;
    int     x   = int'(p % ht);
    int     y   = int'(p / ht);
    e.pt = tick;
    e.hs = (x >= ha + hf && x < ha + hf + hsw) ? hpol : ~hpol;
    e.vs = (y >= va + vf && y < va + vf + vsw) ? vpol : ~vpol;
    e.vo = (x < ha) && (y < va);
    e.x  = 10'(x);
    e.y  = 10'(y);
    e.ls = tick && (x == 0);
    e.fs = tick && (p == 0);
    e.fc = 16'(fc);
    return e;
  endfunction

  // Reference state per instance: enabled clocks, pixel ticks, frames
  longint n_d, ce_d, n_s, ce_s, n_p, ce_p;
  int     fm_d, fm_s, fm_p, fn_d, fn_s, fn_p;
  logic   tk_d, tk_s, tk_p;
  exp_t   q_d[$], q_s[$], q_p[$];

  assign tk_d = en_d;
  assign tk_s = en_s;
  assign tk_p = en_p && (((ce_p + 1) % 3) == 0);
  assign fn_d = fm_d + ((tk_d && ((n_d + 1) % 420000) == 1) ? 1 : 0);
  assign fn_s = fm_s + ((tk_s && ((n_s + 1) % 48) == 1) ? 1 : 0);
  assign fn_p = fm_p + ((tk_p && ((n_p + 1) % 48) == 1) ? 1 : 0);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_d <= 0; ce_d <= 0; fm_d <= 0; q_d.delete();
      n_s <= 0; ce_s <= 0; fm_s <= 0; q_s.delete();
      n_p <= 0; ce_p <= 0; fm_p <= 0; q_p.delete();
    end else begin
      if (en_d) ce_d <= ce_d + 1;
      if (en_s) ce_s <= ce_s + 1;
      if (en_p) ce_p <= ce_p + 1;
      if (tk_d) n_d <= n_d + 1;
      if (tk_s) n_s <= n_s + 1;
      if (tk_p) n_p <= n_p + 1;
      fm_d <= fn_d;
      fm_s <= fn_s;
      fm_p <= fn_p;
      q_d.push_back(f_exp(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, n_d + longint'(tk_d), tk_d, FC_ON ? fn_d : 0));
      q_s.push_back(f_exp(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, n_s + longint'(tk_s), tk_s, FC_ON ? fn_s : 0));
      q_p.push_back(f_exp(4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0, n_p + longint'(tk_p), tk_p, FC_ON ? fn_p : 0));
    end
  end

  localparam exp_t RST_D = {1'b0, 1'b1, 1'b1, 1'b0, 10'd799, 10'd524, 1'b0, 1'b0, 16'd0};
  localparam exp_t RST_S = {1'b0, 1'b0, 1'b0, 1'b0, 10'd7, 10'd5, 1'b0, 1'b0, 16'd0};
  localparam exp_t RST_P = {1'b0, 1'b1, 1'b1, 1'b0, 10'd7, 10'd5, 1'b0, 1'b0, 16'd0};

  task automatic test_reset();
    exp_t e;
    reset_n = 1'b0; en_d = 1'b1; en_s = 1'b1; en_p = 1'b1;
    repeat (3) @(negedge clk);
    total += 3;
    if (act_d !== RST_D) begin bad++; $display("FAIL reset_d: got=%h want=%h", act_d, RST_D); end
    if (act_s !== RST_S) begin bad++; $display("FAIL reset_s: got=%h want=%h", act_s, RST_S); end
    if (act_p !== RST_P) begin bad++; $display("FAIL reset_p: got=%h want=%h", act_p, RST_P); end
    reset_n = 1'b1;
    @(negedge clk);
    total += 3;
    e = {1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 16'(FC_ON ? 1 : 0)};
    if (act_d !== e) begin bad++; $display("FAIL first_tick_d: got=%h want=%h", act_d, e); end
    e = {1'b1, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 16'(FC_ON ? 1 : 0)};
    if (act_s !== e) begin bad++; $display("FAIL first_tick_s: got=%h want=%h", act_s, e); end
    if (act_p !== RST_P) begin bad++; $display("FAIL div_pre_tick_p: got=%h want=%h", act_p, RST_P); end
  endtask

  task automatic test_small_mode();
    exp_t e;
    int   n_hs = 0, n_vs = 0, n_vo = 0, n_ls = 0, n_fs = 0;
    q_s.delete();
    repeat (96) begin
      @(negedge clk);
      total++;
      if (q_s.size() == 0) begin
        bad++; $display("FAIL small_queue: got=empty want=entry");
      end else begin
        e = q_s.pop_front();
        if (act_s !== e) begin bad++; $display("FAIL small_sb: got=%h want=%h", act_s, e); end
      end
      n_hs += int'(hs_s); n_vs += int'(vs_s); n_vo += int'(vo_s);
      n_ls += int'(ls_s); n_fs += int'(fs_s);
    end
    total += 5;
    if (n_hs != 24) begin bad++; $display("FAIL small_hs_count: got=%0d want=24", n_hs); end
    if (n_vs != 16) begin bad++; $display("FAIL small_vs_count: got=%0d want=16", n_vs); end
    if (n_vo != 24) begin bad++; $display("FAIL small_vo_count: got=%0d want=24", n_vo); end
    if (n_ls != 12) begin bad++; $display("FAIL small_ls_count: got=%0d want=12", n_ls); end
    if (n_fs != 2)  begin bad++; $display("FAIL small_fs_count: got=%0d want=2", n_fs); end
  endtask

  task automatic test_pix_div();
    exp_t e;
    int   n_pt = 0, n_ls = 0, n_fs = 0;
    q_p.delete();
    repeat (288) begin
      @(negedge clk);
      total++;
      if (q_p.size() == 0) begin
        bad++; $display("FAIL div_queue: got=empty want=entry");
      end else begin
        e = q_p.pop_front();
        if (act_p !== e) begin bad++; $display("FAIL div_sb: got=%h want=%h", act_p, e); end
      end
      n_pt += int'(pt_p); n_ls += int'(ls_p); n_fs += int'(fs_p);
    end
    total += 3;
    if (n_pt != 96) begin bad++; $display("FAIL div_tick_count: got=%0d want=96", n_pt); end
    if (n_ls != 12) begin bad++; $display("FAIL div_ls_count: got=%0d want=12", n_ls); end
    if (n_fs != 2)  begin bad++; $display("FAIL div_fs_count: got=%0d want=2", n_fs); end
  endtask

  task automatic test_en_freeze();
    exp_t e;
    int   budget = 20000;
    q_d.delete();
    while (!(x_d == 10'd100 && y_d == 10'd20) && budget > 0) begin
      @(negedge clk);
      budget--;
      total++;
      if (q_d.size() == 0) begin
        bad++; $display("FAIL run_queue: got=empty want=entry");
      end else begin
        e = q_d.pop_front();
        if (act_d !== e) begin bad++; $display("FAIL run_sb: got=%h want=%h", act_d, e); end
      end
    end
    total++;
    if (budget == 0) begin bad++; $display("FAIL reach_100_20: got=(%0d,%0d) want=(100,20)", x_d, y_d); end
    en_d = 1'b0;
    repeat (50) begin
      @(negedge clk);
      total += 2;
      e = q_d.pop_front();
      if (act_d !== e) begin bad++; $display("FAIL freeze_sb: got=%h want=%h", act_d, e); end
      if (x_d !== 10'd100 || pt_d !== 1'b0) begin
        bad++; $display("FAIL freeze_hold: got x=%0d pt=%b want x=100 pt=0", x_d, pt_d);
      end
    end
    en_d = 1'b1;
    @(negedge clk);
    total += 2;
    e = q_d.pop_front();
    if (act_d !== e) begin bad++; $display("FAIL resume_sb: got=%h want=%h", act_d, e); end
    if (x_d !== 10'd101 || y_d !== 10'd20 || ls_d !== 1'b0 || fs_d !== 1'b0) begin
      bad++; $display("FAIL resume_pos: got=(%0d,%0d) ls=%b fs=%b want=(101,20) ls=0 fs=0", x_d, y_d, ls_d, fs_d);
    end
    repeat (10) begin
      @(negedge clk);
      total++;
      e = q_d.pop_front();
      if (act_d !== e) begin bad++; $display("FAIL resume_run_sb: got=%h want=%h", act_d, e); end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    int   budget = 100;
    while (!(x_s == 10'd5 && y_s == 10'd3) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    total++;
    if (budget == 0) begin bad++; $display("FAIL reach_5_3: got=(%0d,%0d) want=(5,3)", x_s, y_s); end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    total += 3;
    if (act_d !== RST_D) begin bad++; $display("FAIL async_rst_d: got=%h want=%h", act_d, RST_D); end
    if (act_s !== RST_S) begin bad++; $display("FAIL async_rst_s: got=%h want=%h", act_s, RST_S); end
    if (act_p !== RST_P) begin bad++; $display("FAIL async_rst_p: got=%h want=%h", act_p, RST_P); end
    @(negedge clk);
    reset_n = 1'b1;
    q_s.delete();
    q_p.delete();
    @(negedge clk);
    total++;
    if (fs_s !== 1'b1 || fc_s !== 16'(FC_ON ? 1 : 0)) begin
      bad++; $display("FAIL post_rst_frame: got fs=%b fc=%0d want fs=1 fc=%0d", fs_s, fc_s, FC_ON ? 1 : 0);
    end
    void'(q_s.pop_front());
    void'(q_p.pop_front());
    repeat (100) begin
      @(negedge clk);
      total += 2;
      e = q_s.pop_front();
      if (act_s !== e) begin bad++; $display("FAIL post_rst_s_sb: got=%h want=%h", act_s, e); end
      e = q_p.pop_front();
      if (act_p !== e) begin bad++; $display("FAIL post_rst_p_sb: got=%h want=%h", act_p, e); end
    end
  endtask

  initial begin
    test_reset();
    test_small_mode();
    test_pix_div();
    test_en_freeze();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
